mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle processor's single shared instruction/data bus. It serves reads and writes issued on `MemWrite`/`Adr`/`WriteData` and returns `ReadData` in the same cycle. It decodes the address into four targets:

- a unified word RAM, holding program and data;
- a GPIO output register;
- a free-running timer;
- a byte transmit FIFO with a valid/ready output.

It sits beside the processor at the top level, in place of a flat memory.

## Interface
Parameters:
- `RAM_WORDS`, default 64: RAM depth in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, default 4: TX FIFO depth in bytes; must be a power of two, at most 8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: write strobe for the current `Adr`.
- `Adr` in 32: byte address; `Adr[1:0]` is ignored, so all accesses are word accesses.
- `WriteData` in 32: write data.
- `ReadData` out 32: combinational read data for `Adr`.
- `gpio_out` out 8: GPIO register contents.
- `tx_valid` out 1: FIFO non-empty.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: sink accepts `tx_data`.

## Operation
Address map. The peripheral page is `Adr[31:4] == 28'h8000000`.

RAM, at `0x0000_0000` to `RAM_WORDS*4-1`:
- Read: `RAM[Adr[log2(RAM_WORDS)+1:2]]`.
- Write: full word when `MemWrite` is high.
- Contents are not reset.

GPIO, at `0x8000_0000`, read/write:
- A write stores `WriteData[7:0]`.
- A read returns the value zero-extended.

TIMER, at `0x8000_0004`:
- Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
- A write loads `WriteData` and takes priority over the increment that cycle. The loaded value appears next cycle, and increments resume after that.
- A read returns the current count.

TXDATA, at `0x8000_0008`:
- A write pushes `WriteData[7:0]` if the FIFO is not full.
- If full, the byte is dropped and sticky `ovf` is set.
- A read returns 0.

STATUS, at `0x8000_000C`:
- Read layout: bit0 = empty, bit1 = full, bit2 = `ovf`, bits[7:4] = count, all other bits 0.
- Writing with `WriteData[2]` = 1 clears `ovf`.
- If the clear and an overflowing push coincide, set wins.

Unmapped addresses:
- Reads return `32'hDEADBEEF`.
- Writes are ignored.

FIFO rules:
- `tx_valid` = !empty and `tx_data` = head; both are registered state, with no combinational path from the bus.
- A pop happens when `tx_valid && tx_ready` at a rising edge.
- Push and pop in the same cycle:
  - When full, the pop frees a slot, the push is accepted, the count is unchanged, and `ovf` is not set.
  - When empty, no pop is possible, so only the push happens.
- Pointers wrap modulo `FIFO_DEPTH`. The count ranges from 0 to `FIFO_DEPTH`.

## Timing
- Reads are zero-latency combinational through `Adr` decode. This is required because the processor latches `ReadData` at the end of the same cycle.
- Writes take effect on the rising edge where `MemWrite` is high. A read of the same address in the next cycle returns the new value.
- A pushed byte is visible on `tx_valid`/`tx_data` one cycle after the write edge.
- Asserting `reset` low at any time immediately sets:
  - `gpio_out` = 0
  - timer = 0
  - FIFO empty (`tx_valid` = 0, `tx_data` = 0)
  - `ovf` = 0

  RAM is untouched. A reset mid-transfer discards all queued bytes.
- During reset, `ReadData` still follows decode, returning RAM contents and the register reset values.

## Configuration
- `MEM_TIMER_EN` defined: the TIMER register exists as described.
- `MEM_TIMER_EN` undefined:
  - No counter is built.
  - `0x8000_0004` behaves as unmapped: reads return `32'hDEADBEEF` and writes are ignored.
  - All other behaviour is identical.

## Structure
Package `mem_map_pkg` holds:
- address constants `GPIO_ADR`, `TIMER_ADR`, `TXDATA_ADR`, `STATUS_ADR`, `PERIPH_BASE`;
- `UNMAPPED_DATA` = `32'hDEADBEEF`;
- STATUS bit indices.

Sub-module `tx_fifo`, parameterised by depth, provides:
- inputs: push, push_data, pop;
- outputs: head, empty, full, count.

`mem_responder` contains the decode, the RAM array, GPIO, the timer, `ovf`, and one `tx_fifo` instance.

## Test plan
- **Reset values:** drive `reset` low, then high. Expect `gpio_out` = 0, `tx_valid` = 0, and a STATUS read = `32'h1`.
- **RAM write/read:** write `0x12345678` to `0x10`, then read `0x10`. Expect `ReadData` = `0x12345678`. A read of `0x13` returns the same word.
- **Timer:** with `MEM_TIMER_EN` defined, write `0xFFFF_FFFE` to TIMER. Reads on the next three cycles return `FFFF_FFFE`, `FFFF_FFFF`, then 0. Without the macro, a read returns `DEADBEEF`.
- **FIFO fill and overflow:** with `tx_ready` = 0, push `0xA1`–`0xA5` at `FIFO_DEPTH` = 4. Expect STATUS = `32'h46`. Then clear `ovf` (write `0x4`) and expect STATUS = `32'h42`.
- **Drain:** raise `tx_ready` and expect `tx_data` = A1, A2, A3, A4 on consecutive edges, then `tx_valid` = 0.
- **Full with simultaneous push and pop:** with the FIFO full and `tx_ready` = 1, push `0xB0`. Expect `ovf` = 0, count stays 4, and `0xB0` appears after A4.
- **Unmapped access:** reading `0x4000_0000` returns `DEADBEEF`. A write there changes no observable state.

Source files
------------

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map, fill value and STATUS layout for mem_responder.
// Rev 1.0
`default_nettype none

package mem_map_pkg;

  localparam logic [31:0] PERIPH_BASE   = 32'h8000_0000;
  localparam logic [31:0] GPIO_ADR      = 32'h8000_0000;
  localparam logic [31:0] TIMER_ADR     = 32'h8000_0004;
  localparam logic [31:0] TXDATA_ADR    = 32'h8000_0008;
  localparam logic [31:0] STATUS_ADR    = 32'h8000_000C;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 4;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic [3:0] count);
    status_word = '0;
    status_word[STAT_EMPTY] = empty;
    status_word[STAT_FULL]  = full;
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_COUNT_LSB +: 4] = count;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with registered head/flags; DEPTH is a power of two, at most 8.
// Rev 1.0
`default_nettype none

module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic [3:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is reset too so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 4'd0);
  assign full  = (count == 4'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: RAM + GPIO + timer + TX FIFO behind one word bus.
// Rev 1.0; the TIMER register is built only when MEM_TIMER_EN is defined.
`default_nettype none

module mem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram [RAM_WORDS];
  logic        ram_sel, periph_sel, gpio_sel, timer_sel, txdata_sel, status_sel;
  logic        fifo_empty, fifo_full, push_req, push, pop, ovf_set, ovf_clr, ovf;
  logic [3:0]  fifo_count;

  assign ram_sel    = (Adr[31:AW+2] == '0);
  assign periph_sel = (Adr[31:4] == PERIPH_BASE[31:4]);
  assign gpio_sel   = periph_sel && (Adr[3:2] == GPIO_ADR[3:2]);
  assign timer_sel  = periph_sel && (Adr[3:2] == TIMER_ADR[3:2]);
  assign txdata_sel = periph_sel && (Adr[3:2] == TXDATA_ADR[3:2]);
  assign status_sel = periph_sel && (Adr[3:2] == STATUS_ADR[3:2]);

  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) ram[Adr[AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    gpio_out <= '0;
    else if (MemWrite && gpio_sel) gpio_out <= WriteData[7:0];
  end

`ifdef MEM_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     timer <= '0;
    else if (MemWrite && timer_sel) timer <= WriteData;
    else                            timer <= timer + 32'd1;
  end
`endif

  // A pop in the same cycle frees the slot, so a push to a full FIFO is not an overflow.
  assign pop      = !fifo_empty && tx_ready;
  assign push_req = MemWrite && txdata_sel;
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = MemWrite && status_sel && WriteData[STAT_OVF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_data(WriteData[7:0]),
    .pop      (pop),
    .head     (tx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign tx_valid = !fifo_empty;

  always_comb begin
    ReadData = UNMAPPED_DATA;
    if (ram_sel)         ReadData = ram[Adr[AW+1:2]];
    else if (gpio_sel)   ReadData = {24'h0, gpio_out};
`ifdef MEM_TIMER_EN
    else if (timer_sel)  ReadData = timer;
`endif
    else if (txdata_sel) ReadData = '0;
    else if (status_sel) ReadData = status_word(fifo_empty, fifo_full, ovf, fifo_count);
  end

`ifdef MEM_TIMER_EN
  logic unused_bits;
  assign unused_bits = ^Adr[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{Adr[1:0], timer_sel};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus a randomized run against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_mem_responder;
  import mem_map_pkg::*;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(RAM_WORDS);

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the randomized run
  logic [31:0] m_ram [RAM_WORDS];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [7:0]  m_gpio;

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Adr      (Adr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .gpio_out (gpio_out),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite  = we;
    Adr       = a;
    WriteData = d;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int          n;
    w = {a[31:2], 2'b00};
    n = m_q.size();
    if (a < 32'(RAM_WORDS * 4)) return m_ram[a[AW+1:2]];
    if (w == GPIO_ADR)   return {24'h0, m_gpio};
    if (w == TXDATA_ADR) return 32'h0;
    if (w == STATUS_ADR) return {24'h0, 4'(n), 1'b0, m_ovf, n == FIFO_DEPTH, n == 0};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; Adr = STATUS_ADR; WriteData = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h expected %h", ReadData, 32'h1); end
    n_checks++; if (gpio_out !== 8'h0) begin n_fail++; $display("FAIL reset_gpio: got %h expected 00", gpio_out); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
`ifdef MEM_TIMER_EN
    Adr = TIMER_ADR; #1;
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_timer: got %h expected 0", ReadData); end
`endif
    @(negedge clk); reset = 1'b1;
    drive(1'b1, GPIO_ADR, 32'h5A);
    drive(1'b1, TXDATA_ADR, 32'h3C);
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h10) begin n_fail++; $display("FAIL one_byte_status: got %h expected %h", ReadData, 32'h10); end
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin n_fail++; $display("FAIL one_byte_head: got %b/%h expected 1/3c", tx_valid, tx_data); end
    // Asynchronous reset between edges must clear state at once
    #2 reset = 1'b0;
    #1;
    n_checks++; if (gpio_out !== 8'h0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got gpio %h valid %b expected 00/0", gpio_out, tx_valid); end
    n_checks++; if (ReadData !== 32'h1) begin n_fail++; $display("FAIL async_reset_status: got %h expected 1", ReadData); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_ram();
    drive(1'b1, 32'h10, 32'h1234_5678);
    drive(1'b1, 32'hFC, 32'hCAFE_F00D);
    drive(1'b0, 32'h10, 32'h0);
    n_checks++; if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rd_10: got %h expected 12345678", ReadData); end
    drive(1'b0, 32'h13, 32'h0);
    n_checks++; if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rd_13: got %h expected 12345678", ReadData); end
    drive(1'b0, 32'hFC, 32'h0);
    n_checks++; if (ReadData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_rd_top: got %h expected cafef00d", ReadData); end
    drive(1'b0, 32'h100, 32'h0);
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_past_end: got %h expected deadbeef", ReadData); end
  endtask

  task automatic test_gpio();
    drive(1'b1, GPIO_ADR, 32'h1234_56C3);
    drive(1'b0, GPIO_ADR, 32'h0);
    n_checks++; if (gpio_out !== 8'hC3) begin n_fail++; $display("FAIL gpio_out: got %h expected c3", gpio_out); end
    n_checks++; if (ReadData !== 32'hC3) begin n_fail++; $display("FAIL gpio_rd: got %h expected 000000c3", ReadData); end
  endtask

  task automatic test_timer();
`ifdef MEM_TIMER_EN
    logic [31:0] exp_t [3];
    exp_t = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    drive(1'b1, TIMER_ADR, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, TIMER_ADR, 32'h0);
      n_checks++; if (ReadData !== exp_t[i]) begin n_fail++; $display("FAIL timer_%0d: got %h expected %h", i, ReadData, exp_t[i]); end
    end
`else
    drive(1'b1, TIMER_ADR, 32'h5555_5555);
    drive(1'b0, TIMER_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timer_absent: got %h expected deadbeef", ReadData); end
`endif
  endtask

  task automatic test_fifo_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, TXDATA_ADR, 32'hA1 + 32'(i));
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h46) begin n_fail++; $display("FAIL ovf_status: got %h expected 46", ReadData); end
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin n_fail++; $display("FAIL ovf_head: got %b/%h expected 1/a1", tx_valid, tx_data); end
    drive(1'b0, TXDATA_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL txdata_rd: got %h expected 0", ReadData); end
    drive(1'b1, STATUS_ADR, 32'h4);
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h42) begin n_fail++; $display("FAIL ovf_clear: got %h expected 42", ReadData); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_b;
    @(negedge clk);
    tx_ready = 1'b1; MemWrite = 1'b0; Adr = STATUS_ADR;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      exp_b = 8'hA1 + 8'(i);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin n_fail++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, exp_b); end
    end
    @(negedge clk); #1;
    n_checks++; if (tx_valid !== 1'b0 || ReadData !== 32'h1) begin n_fail++; $display("FAIL drain_end: got %b/%h expected 0/00000001", tx_valid, ReadData); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB0};
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, TXDATA_ADR, 32'hA1 + 32'(i));
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h42) begin n_fail++; $display("FAIL full_status: got %h expected 42", ReadData); end
    @(negedge clk);
    tx_ready = 1'b1; MemWrite = 1'b1; Adr = TXDATA_ADR; WriteData = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, STATUS_ADR, 32'h0);
      if (i == 0) begin
        n_checks++; if (ReadData !== 32'h42) begin n_fail++; $display("FAIL pushpop_status: got %h expected 42", ReadData); end
      end
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin n_fail++; $display("FAIL pushpop_%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, exp_q[i]); end
    end
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (ReadData !== 32'h1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_end: got %h/%b expected 00000001/0", ReadData, tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_unmapped();
    apply_reset();
    drive(1'b1, GPIO_ADR, 32'h77);
    drive(1'b1, 32'h0, 32'h0BAD_F00D);
    drive(1'b0, 32'h4000_0000, 32'h0);
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_rd: got %h expected deadbeef", ReadData); end
    drive(1'b1, 32'h4000_0000, 32'hFFFF_FFFF);
    drive(1'b1, 32'h8000_0010, 32'hFFFF_FFFF);
    drive(1'b0, 32'h8000_0010, 32'h0);
    n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_page_end: got %h expected deadbeef", ReadData); end
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (ReadData !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL unmapped_ram0: got %h expected 0badf00d", ReadData); end
    drive(1'b0, STATUS_ADR, 32'h0);
    n_checks++; if (gpio_out !== 8'h77 || ReadData !== 32'h1) begin n_fail++; $display("FAIL unmapped_side_effect: got %h/%h expected 77/00000001", gpio_out, ReadData); end
  endtask

  task automatic test_random();
    logic [31:0] unm [4];
    logic [31:0] a, d, exp_rd, w;
    logic        we, pop, push_req, set;
    unm = '{32'h4000_0000, 32'h0000_0100, 32'h8000_0010, 32'hFFFF_FFFC};
    apply_reset();
    m_q.delete(); m_ovf = 1'b0; m_gpio = 8'h0;
    for (int i = 0; i < RAM_WORDS; i++) begin
      d = $urandom();
      m_ram[i] = d;
      drive(1'b1, 32'(i * 4), d);
    end
    for (int c = 0; c < 400; c++) begin
      we = 1'b0; d = $urandom();
      case ($urandom_range(0, 7))
        0: begin we = 1'b1; a = 32'($urandom_range(0, RAM_WORDS * 4 - 1)); end
        1: a = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
        2: begin we = $urandom_range(0, 1) == 1; a = GPIO_ADR | 32'($urandom_range(0, 3)); end
        3, 7: begin we = $urandom_range(0, 3) != 0; a = TXDATA_ADR | 32'($urandom_range(0, 3)); end
        4: begin we = 1'b1; a = STATUS_ADR; end
        5: a = STATUS_ADR | 32'($urandom_range(0, 3));
        default: begin we = $urandom_range(0, 1) == 1; a = unm[$urandom_range(0, 3)]; end
      endcase
      @(negedge clk);
      MemWrite = we; Adr = a; WriteData = d;
      tx_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      exp_rd = model_read(a);
      n_checks++; if (ReadData !== exp_rd) begin n_fail++; $display("FAIL rnd_rd c%0d adr %h: got %h expected %h", c, a, ReadData, exp_rd); end
      n_checks++; if (gpio_out !== m_gpio) begin n_fail++; $display("FAIL rnd_gpio c%0d: got %h expected %h", c, gpio_out, m_gpio); end
      n_checks++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, tx_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_checks++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", c, tx_data, m_q[0]); end
      end
      // Advance the model across the coming rising edge
      w        = {a[31:2], 2'b00};
      pop      = (m_q.size() != 0) && tx_ready;
      push_req = we && (w == TXDATA_ADR);
      set      = push_req && (m_q.size() == FIFO_DEPTH) && !pop;
      if (we && a < 32'(RAM_WORDS * 4)) m_ram[a[AW+1:2]] = d;
      if (we && w == GPIO_ADR) m_gpio = d[7:0];
      if (pop) void'(m_q.pop_front());
      if (push_req && !set) m_q.push_back(d[7:0]);
      if (set) m_ovf = 1'b1;
      else if (we && w == STATUS_ADR && d[2]) m_ovf = 1'b0;
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_fifo_overflow();
    test_drain();
    test_full_push_pop();
    test_unmapped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
